// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the datapath ALU: drives the op select, waits out the ALU latency,
// then turns the ALU flags into writeback/branch/done strobes and keeps sticky Z/N flags.
module alu_op_sequencer #(
  parameter int ALU_LATENCY = 1,
  parameter int OPW         = 4
) (
  input  logic           clk,
  input  logic           in_rst_n,
  input  logic           in_instr_valid,
  output logic           out_instr_ready,
  input  logic [OPW-1:0] in_opcode,
  output logic [2:0]     out_ctrl_aluop,
  input  logic           in_alu_zero,
  input  logic           in_alu_neg,
  output logic           out_reg_we,
  output logic           out_branch_taken,
  output logic           out_done,
  output logic           out_illegal,
  output logic           out_flag_z,
  output logic           out_flag_n
);

  typedef enum logic [1:0] {IDLE, EXEC, EVAL} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_ALU_Z, BR_ALU_N, BR_FLAG_Z, BR_FLAG_N} br_t;

  typedef struct packed {
    logic       alu;
    logic [2:0] aluop;
    logic       we;
    logic       upd;
    br_t        br;
    logic       ill;
  } dec_t;

  localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY);

  function automatic dec_t decode(input logic [OPW-1:0] op);
    dec_t d;
    d = '{alu: 1'b0, aluop: 3'b111, we: 1'b0, upd: 1'b0, br: BR_NONE, ill: 1'b0};
    case (op)
      OPW'(0):  ;
      OPW'(1):  d = '{alu: 1'b1, aluop: 3'b100, we: 1'b1, upd: 1'b1, br: BR_NONE,   ill: 1'b0};
      OPW'(2):  d = '{alu: 1'b1, aluop: 3'b010, we: 1'b1, upd: 1'b1, br: BR_NONE,   ill: 1'b0};
      OPW'(3):  d = '{alu: 1'b1, aluop: 3'b001, we: 1'b1, upd: 1'b1, br: BR_NONE,   ill: 1'b0};
      OPW'(4):  d = '{alu: 1'b1, aluop: 3'b000, we: 1'b1, upd: 1'b1, br: BR_NONE,   ill: 1'b0};
      OPW'(5):  d = '{alu: 1'b1, aluop: 3'b111, we: 1'b1, upd: 1'b0, br: BR_NONE,   ill: 1'b0};
      OPW'(6):  d = '{alu: 1'b1, aluop: 3'b111, we: 1'b0, upd: 1'b0, br: BR_ALU_Z,  ill: 1'b0};
      OPW'(7):  d = '{alu: 1'b1, aluop: 3'b111, we: 1'b0, upd: 1'b0, br: BR_ALU_N,  ill: 1'b0};
      OPW'(8):  d = '{alu: 1'b1, aluop: 3'b000, we: 1'b0, upd: 1'b1, br: BR_NONE,   ill: 1'b0};
      OPW'(9):  d.br = BR_FLAG_Z;
      OPW'(10): d.br = BR_FLAG_N;
      default:  d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic take_branch(input br_t br, input logic az, input logic an,
                                       input logic fz, input logic fn);
    case (br)
      BR_ALU_Z:  return az;
      BR_ALU_N:  return an;
      BR_FLAG_Z: return fz;
      BR_FLAG_N: return fn;
      default:   return 1'b0;
    endcase
  endfunction

  state_t     state;
  logic [2:0] cnt;
  dec_t       dec_in;
  dec_t       dec_p0;

  always_comb begin
    dec_in = decode(in_opcode);
  end

  assign out_instr_ready = (state == IDLE);

  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      dec_p0           <= '{alu: 1'b0, aluop: 3'b111, we: 1'b0, upd: 1'b0, br: BR_NONE, ill: 1'b0};
      out_ctrl_aluop   <= 3'b111;
      out_reg_we       <= 1'b0;
      out_branch_taken <= 1'b0;
      out_done         <= 1'b0;
      out_illegal      <= 1'b0;
      out_flag_z       <= 1'b0;
      out_flag_n       <= 1'b0;
    end else begin
      out_reg_we       <= 1'b0;
      out_branch_taken <= 1'b0;
      out_done         <= 1'b0;
      out_illegal      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_instr_valid) begin
            dec_p0 <= dec_in;
            if (dec_in.alu) begin
              out_ctrl_aluop <= dec_in.aluop;
              cnt            <= CNT_INIT;
              state          <= EXEC;
            end else begin
              // non-ALU ops hold one extra cycle in EVAL so every opcode completes 2+ edges after accept
              cnt   <= 3'd1;
              state <= EVAL;
            end
          end
        end
        EXEC: begin
          if (cnt == 3'd1) begin
            cnt   <= 3'd0;
            state <= EVAL;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        EVAL: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            out_done         <= 1'b1;
            out_reg_we       <= dec_p0.we;
            out_illegal      <= dec_p0.ill;
            out_branch_taken <= take_branch(dec_p0.br, in_alu_zero, in_alu_neg,
                                            out_flag_z, out_flag_n);
            if (dec_p0.upd) begin
              out_flag_z <= in_alu_zero;
              out_flag_n <= in_alu_neg;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one instance at ALU_LATENCY=1, one at ALU_LATENCY=3,
// each driven against a small registered ALU model.
module tb_alu_op_sequencer;

  typedef struct {
    logic       we;
    logic       br;
    logic       ill;
    logic       fz;
    logic       fn;
    logic [2:0] aluop;
    int         lat;
    int         acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      vld;
  logic [1:0]      rdy;
  logic [1:0][3:0] opc;
  logic [1:0][2:0] aluop;
  logic [1:0]      az, an;
  logic [1:0]      we, br, done, ill, fz, fn;

  logic [7:0] opa [2];
  logic [7:0] opb [2];
  logic       frc [2];
  logic [7:0] alu_r [2];

  logic       mz [2];
  logic       mn [2];
  logic [2:0] maluop [2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LATENCY(1), .OPW(4)) dut1 (
    .clk(clk), .in_rst_n(rst_n), .in_instr_valid(vld[0]), .out_instr_ready(rdy[0]),
    .in_opcode(opc[0]), .out_ctrl_aluop(aluop[0]), .in_alu_zero(az[0]), .in_alu_neg(an[0]),
    .out_reg_we(we[0]), .out_branch_taken(br[0]), .out_done(done[0]), .out_illegal(ill[0]),
    .out_flag_z(fz[0]), .out_flag_n(fn[0])
  );

  alu_op_sequencer #(.ALU_LATENCY(3), .OPW(4)) dut3 (
    .clk(clk), .in_rst_n(rst_n), .in_instr_valid(vld[1]), .out_instr_ready(rdy[1]),
    .in_opcode(opc[1]), .out_ctrl_aluop(aluop[1]), .in_alu_zero(az[1]), .in_alu_neg(an[1]),
    .out_reg_we(we[1]), .out_branch_taken(br[1]), .out_done(done[1]), .out_illegal(ill[1]),
    .out_flag_z(fz[1]), .out_flag_n(fn[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b100:  return a + b;
      3'b010:  return a + 8'd1;
      3'b001:  return -a;
      3'b000:  return b - a;
      default: return a;
    endcase
  endfunction

  // ALU model: one register stage from op select to flags
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      alu_r[i] = alu(aluop[i], opa[i], opb[i]);
      az[i] <= (alu_r[i] == 8'd0);
      an[i] <= alu_r[i][7] | frc[i];
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        chk("ready_at_done", {31'd0, rdy[i]}, 32'd1);
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e_mon = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("reg_we",       {31'd0, we[i]},  {31'd0, e_mon.we});
          chk("branch_taken", {31'd0, br[i]},  {31'd0, e_mon.br});
          chk("illegal",      {31'd0, ill[i]}, {31'd0, e_mon.ill});
          chk("flag_z",       {31'd0, fz[i]},  {31'd0, e_mon.fz});
          chk("flag_n",       {31'd0, fn[i]},  {31'd0, e_mon.fn});
          chk("aluop_done",   {29'd0, aluop[i]}, {29'd0, e_mon.aluop});
          chk("latency",      cyc - e_mon.acc, e_mon.lat);
        end
      end else if (we[i] | br[i] | ill[i]) begin
        chk("pulse_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input int i, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic fneg, input logic hold);
    exp_t e;
    int n;
    logic [7:0] r;
    logic [2:0] ao;
    logic z, ng, isalu;
    n = 0;
    @(negedge clk);
    while (!rdy[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    vld[i] = 1'b1;
    opc[i] = op;
    opa[i] = a;
    opb[i] = b;
    frc[i] = fneg;
    isalu = (op >= 4'd1 && op <= 4'd8);
    case (op)
      4'd1:       begin ao = 3'b100; r = a + b;    end
      4'd2:       begin ao = 3'b010; r = a + 8'd1; end
      4'd3:       begin ao = 3'b001; r = -a;       end
      4'd4, 4'd8: begin ao = 3'b000; r = b - a;    end
      4'd5, 4'd6, 4'd7: begin ao = 3'b111; r = a; end
      default:    begin ao = maluop[i]; r = 8'd0;  end
    endcase
    z  = (r == 8'd0);
    ng = r[7] | fneg;
    e.aluop = ao;
    maluop[i] = ao;
    e.we  = (op >= 4'd1 && op <= 4'd5);
    e.ill = (op >= 4'd11);
    e.br  = (op == 4'd6) ? z : (op == 4'd7) ? ng : (op == 4'd9) ? mz[i] :
            (op == 4'd10) ? mn[i] : 1'b0;
    if (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd8}) begin
      mz[i] = z;
      mn[i] = ng;
    end
    e.fz  = mz[i];
    e.fn  = mn[i];
    e.lat = isalu ? ((i == 0) ? 2 : 4) : 2;
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    chk("ready_low_after_accept", {31'd0, rdy[i]}, 32'd0);
    if (isalu) chk("aluop_after_accept", {29'd0, aluop[i]}, {29'd0, ao});
    if (!hold) vld[i] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mz[i] = 1'b0;
      mn[i] = 1'b0;
      maluop[i] = 3'b111;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    vld = '0;
    opc = '0;
    for (int i = 0; i < 2; i++) begin
      opa[i] = 8'd0;
      opb[i] = 8'd0;
      frc[i] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_aluop", {29'd0, aluop[i]}, 32'd7);
      chk("reset_ready", {31'd0, rdy[i]}, 32'd1);
      chk("reset_outs", {26'd0, done[i], we[i], br[i], ill[i], fz[i], fn[i]}, 32'd0);
    end

    issue(0, 4'd1, 8'd3, 8'd5, 1'b0, 1'b0);   // ADD 3+5
    issue(0, 4'd4, 8'd7, 8'd7, 1'b0, 1'b0);   // SUB -> zero
    issue(0, 4'd9, 8'd0, 8'd0, 1'b0, 1'b0);   // BZF taken
    issue(0, 4'd8, 8'd1, 8'd2, 1'b1, 1'b0);   // CMP, forced neg
    issue(0, 4'd7, 8'd5, 8'd0, 1'b0, 1'b0);   // BRN not taken
    issue(0, 4'd15, 8'd0, 8'd0, 1'b0, 1'b0);  // illegal
    issue(0, 4'd10, 8'd0, 8'd0, 1'b0, 1'b0);  // BNF taken
    issue(0, 4'd3, 8'd1, 8'd0, 1'b0, 1'b0);   // NEG 1 -> 0xFF
    issue(0, 4'd6, 8'd0, 8'd9, 1'b0, 1'b0);   // BRZ taken
    issue(0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);   // NOP
    issue(0, 4'd5, 8'h80, 8'd0, 1'b0, 1'b0);  // MOV

    // reset pulse while ADD is in EXEC
    issue(0, 4'd1, 8'd1, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_aluop", {29'd0, aluop[0]}, 32'd7);
    chk("rst_mid_flags", {30'd0, fz[0], fn[0]}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy[0]}, 32'd1);
    repeat (4) @(negedge clk);

    // back-to-back INCs with valid held on the latency-3 instance
    issue(1, 4'd2, 8'd1, 8'd0, 1'b0, 1'b1);
    issue(1, 4'd2, 8'hFF, 8'd0, 1'b0, 1'b1);
    issue(1, 4'd2, 8'h7F, 8'd0, 1'b0, 1'b0);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
